// File: rtl/mem_arb_pkg.sv
// Shared types and address-map constants for the Hack memory arbiter.
package mem_arb_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_e;

    localparam logic [14:0] SCREEN_BASE = 15'h4000;
    localparam logic [14:0] KBD_ADDR    = 15'h6000;
    localparam logic [14:0] WRITE_LIMIT = 15'h6000;

    // RAM and screen are writable; keyboard and everything above are not.
    function automatic logic is_writable(input logic [14:0] addr);
        return addr < WRITE_LIMIT;
    endfunction

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational winner selection between CPU (bit 0) and DMA (bit 1).
module arb_pick
    import mem_arb_pkg::*;
#(
    parameter bit CPU_PRIORITY = 1'b1
) (
    input  logic       [1:0] reqs,
    input  owner_e           last_winner,
    input  logic             starve_full,
    input  arb_state_e       state,
    output logic       [1:0] grant
);

    // One-hot grant: locked bursts exclude the CPU, ties honour starvation first.
    always_comb begin
        grant = 2'b00;
        if (state == LOCK) begin
            grant[1] = reqs[1];
        end else begin
            unique case (reqs)
                2'b01: grant = 2'b01;
                2'b10: grant = 2'b10;
                2'b11: begin
                    if (starve_full) begin
                        grant = 2'b10;
                    end else if (CPU_PRIORITY) begin
                        grant = 2'b01;
                    end else begin
                        grant = (last_winner == OWN_CPU) ? 2'b10 : 2'b01;
                    end
                end
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter (CPU, DMA) in front of the single-port Hack memory map.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX   = 4,
    parameter bit          CPU_PRIORITY = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [14:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [15:0] cpu_rdata,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic        dma_lock,
    input  logic [14:0] dma_addr,
    input  logic [15:0] dma_wdata,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [15:0] dma_rdata,
    output logic [15:0] mem_in,
    output logic        mem_load,
    output logic [14:0] mem_address,
    input  logic [15:0] mem_out,
    output logic        wr_err
);

    localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    arb_state_e    state_q;
    owner_e        last_q;
    owner_e        owner_q;
    logic [SW-1:0] starve_q;
    logic [14:0]   addr_q;
    logic          wr_err_q;
    logic          rvalid_q;
    logic [15:0]   cpu_rdata_q;
    logic [15:0]   dma_rdata_q;

    arb_state_e  state_eff;
    logic [1:0]  pick;
    logic [1:0]  grant;
    logic        any_gnt;
    logic        sel_we;
    logic [14:0] sel_addr;
    logic [15:0] sel_wdata;
    logic        write_ok;
    logic        rd_issue;
    logic        bad_write;

    // The cycle a lock or request drops is already arbitrated as ARB.
    always_comb begin
        state_eff = ((state_q == LOCK) && dma_req && dma_lock) ? LOCK : ARB;
    end

    arb_pick #(
        .CPU_PRIORITY (CPU_PRIORITY)
    ) u_pick (
        .reqs        ({dma_req, cpu_req}),
        .last_winner (last_q),
        .starve_full (starve_q == SMAX),
        .state       (state_eff),
        .grant       (pick)
    );

    // Grant mux and memory-side drive; grants are forced low while in reset.
    always_comb begin
        grant     = pick & {2{reset_n}};
        any_gnt   = |grant;
        sel_we    = grant[1] ? dma_we    : cpu_we;
        sel_addr  = grant[1] ? dma_addr  : cpu_addr;
        sel_wdata = grant[1] ? dma_wdata : cpu_wdata;
        write_ok  = is_writable(sel_addr);
        rd_issue  = any_gnt & ~sel_we;
        bad_write = any_gnt & sel_we & ~write_ok;

        cpu_gnt     = grant[0];
        dma_gnt     = grant[1];
        mem_load    = any_gnt & sel_we & write_ok;
        mem_address = any_gnt ? sel_addr : addr_q;
        mem_in      = any_gnt ? sel_wdata : 16'h0000;
        wr_err      = wr_err_q;
        cpu_rvalid  = rvalid_q & (owner_q == OWN_CPU);
        dma_rvalid  = rvalid_q & (owner_q == OWN_DMA);
        cpu_rdata   = cpu_rdata_q;
        dma_rdata   = dma_rdata_q;
    end

    // Arbitration FSM plus fairness bookkeeping.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ARB;
            last_q   <= OWN_DMA;
            starve_q <= '0;
        end else begin
            state_q <= (grant[1] && dma_lock) ? LOCK : ARB;
            if (any_gnt) begin
                last_q <= grant[1] ? OWN_DMA : OWN_CPU;
            end
            if (grant[1] || !dma_req) begin
                starve_q <= '0;
            end else if (grant[0] && (starve_q != SMAX)) begin
                starve_q <= starve_q + 1'b1;
            end
        end
    end

    // Address hold, write-error pulse and read-return capture with owner tag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_q      <= '0;
            wr_err_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            owner_q     <= OWN_CPU;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            if (any_gnt) begin
                addr_q <= sel_addr;
            end
            wr_err_q <= bad_write;
            rvalid_q <= rd_issue;
            if (rd_issue) begin
                owner_q <= grant[1] ? OWN_DMA : OWN_CPU;
                if (grant[1]) begin
                    dma_rdata_q <= mem_out;
                end else begin
                    cpu_rdata_q <= mem_out;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural Hack memory model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam logic [15:0] SCANCODE = 16'h0041;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [14:0] cpu_addr;
    logic [15:0] cpu_wdata, cpu_rdata;
    logic        dma_req, dma_we, dma_lock, dma_gnt, dma_rvalid;
    logic [14:0] dma_addr;
    logic [15:0] dma_wdata, dma_rdata;
    logic [15:0] mem_in, mem_out;
    logic        mem_load, wr_err;
    logic [14:0] mem_address;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    mem_arbiter #(
        .STARVE_MAX   (4),
        .CPU_PRIORITY (1'b1)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_gnt     (cpu_gnt),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_rdata   (cpu_rdata),
        .dma_req     (dma_req),
        .dma_we      (dma_we),
        .dma_lock    (dma_lock),
        .dma_addr    (dma_addr),
        .dma_wdata   (dma_wdata),
        .dma_gnt     (dma_gnt),
        .dma_rvalid  (dma_rvalid),
        .dma_rdata   (dma_rdata),
        .mem_in      (mem_in),
        .mem_load    (mem_load),
        .mem_address (mem_address),
        .mem_out     (mem_out),
        .wr_err      (wr_err)
    );

    // Memory model: combinational read, keyboard at KBD_ADDR, clocked write.
    logic [15:0] ram [0:32767];
    logic        preloaded = 1'b0;

    assign mem_out = (mem_address == KBD_ADDR) ? SCANCODE : ram[mem_address];

    always @(posedge clock) begin
        if (!preloaded) begin
            for (int a = 0; a < 32768; a++) ram[a] <= 16'h0000;
            ram[1]                 <= 16'hAAAA;
            ram[2]                 <= 16'hBBBB;
            ram[SCREEN_BASE + 15'd1] <= 16'hC0DE;
            preloaded <= 1'b1;
        end else if (mem_load) begin
            ram[mem_address] <= mem_in;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_lock = 1'b0; dma_addr = '0; dma_wdata = '0;
    endtask

    // ctl = {cpu_req,cpu_we,dma_req,dma_we,dma_lock}
    // flg = {cpu_gnt,dma_gnt,mem_load,wr_err,cpu_rvalid,dma_rvalid}
    typedef struct {
        logic [4:0]  ctl;
        logic [14:0] ca;
        logic [15:0] cd;
        logic [14:0] da;
        logic [15:0] dd;
        logic [5:0]  flg;
        logic [14:0] ad;
        logic [15:0] crd;
        logic [15:0] drd;
    } vec_t;

    localparam int NV = 16;
    vec_t v [NV];

    initial begin
        v[0]  = '{5'b00000, 15'h0000, 16'h0000, 15'h0000, 16'h0000, 6'b000000, 15'h0000, 16'h0000, 16'h0000};
        v[1]  = '{5'b11000, 15'h0010, 16'h1234, 15'h0000, 16'h0000, 6'b101000, 15'h0010, 16'h0000, 16'h0000};
        v[2]  = '{5'b10000, 15'h0010, 16'h0000, 15'h0000, 16'h0000, 6'b100000, 15'h0010, 16'h0000, 16'h0000};
        v[3]  = '{5'b00000, 15'h0000, 16'h0000, 15'h0000, 16'h0000, 6'b000010, 15'h0010, 16'h1234, 16'h0000};
        v[4]  = '{5'b00000, 15'h0000, 16'h0000, 15'h0000, 16'h0000, 6'b000000, 15'h0010, 16'h1234, 16'h0000};
        v[5]  = '{5'b11000, 15'h6000, 16'hFFFF, 15'h0000, 16'h0000, 6'b100000, 15'h6000, 16'h1234, 16'h0000};
        v[6]  = '{5'b10000, 15'h6000, 16'h0000, 15'h0000, 16'h0000, 6'b100100, 15'h6000, 16'h1234, 16'h0000};
        v[7]  = '{5'b00000, 15'h0000, 16'h0000, 15'h0000, 16'h0000, 6'b000010, 15'h6000, 16'h0041, 16'h0000};
        v[8]  = '{5'b10000, 15'h0001, 16'h0000, 15'h0000, 16'h0000, 6'b100000, 15'h0001, 16'h0041, 16'h0000};
        v[9]  = '{5'b00100, 15'h0000, 16'h0000, 15'h4001, 16'h0000, 6'b010010, 15'h4001, 16'hAAAA, 16'h0000};
        v[10] = '{5'b10000, 15'h0002, 16'h0000, 15'h0000, 16'h0000, 6'b100001, 15'h0002, 16'hAAAA, 16'hC0DE};
        v[11] = '{5'b00000, 15'h0000, 16'h0000, 15'h0000, 16'h0000, 6'b000010, 15'h0002, 16'hBBBB, 16'hC0DE};
        v[12] = '{5'b00110, 15'h0000, 16'h0000, 15'h7000, 16'h0001, 6'b010000, 15'h7000, 16'hBBBB, 16'hC0DE};
        v[13] = '{5'b00000, 15'h0000, 16'h0000, 15'h0000, 16'h0000, 6'b000100, 15'h7000, 16'hBBBB, 16'hC0DE};
        v[14] = '{5'b11000, 15'h5FFF, 16'h5A5A, 15'h0000, 16'h0000, 6'b101000, 15'h5FFF, 16'hBBBB, 16'hC0DE};
        v[15] = '{5'b00000, 15'h0000, 16'h0000, 15'h0000, 16'h0000, 6'b000000, 15'h5FFF, 16'hBBBB, 16'hC0DE};

        idle_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;

        // Table: single-requester traffic, write rejection, interleaved reads.
        for (int i = 0; i < NV; i++) begin
            {cpu_req, cpu_we, dma_req, dma_we, dma_lock} = v[i].ctl;
            cpu_addr = v[i].ca; cpu_wdata = v[i].cd;
            dma_addr = v[i].da; dma_wdata = v[i].dd;
            @(negedge clock);
            chk($sformatf("v%0d.flags", i),
                32'({cpu_gnt, dma_gnt, mem_load, wr_err, cpu_rvalid, dma_rvalid}),
                32'(v[i].flg));
            chk($sformatf("v%0d.mem_address", i), 32'(mem_address), 32'(v[i].ad));
            chk($sformatf("v%0d.cpu_rdata", i), 32'(cpu_rdata), 32'(v[i].crd));
            chk($sformatf("v%0d.dma_rdata", i), 32'(dma_rdata), 32'(v[i].drd));
            @(posedge clock); #1;
        end
        idle_inputs();
        chk("ram_5fff_written", 32'(ram[15'h5FFF]), 32'h5A5A);
        chk("ram_6000_untouched", 32'(ram[15'h6000]), 32'h0000);
        chk("ram_7000_untouched", 32'(ram[15'h7000]), 32'h0000);

        // Starvation bound: both requesting, expect C,C,C,C,D repeating.
        cpu_req = 1'b1; cpu_addr = 15'h0003;
        dma_req = 1'b1; dma_addr = 15'h0004;
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            chk($sformatf("starve.%0d", i), 32'({cpu_gnt, dma_gnt}),
                (i % 5 == 4) ? 32'b01 : 32'b10);
            @(posedge clock); #1;
        end
        idle_inputs();
        @(posedge clock); #1;

        // Locked DMA burst with the CPU waiting.
        for (int i = 0; i < 8; i++) begin
            dma_req = 1'b1; dma_we = 1'b1; dma_lock = 1'b1;
            dma_addr = SCREEN_BASE + 15'(i); dma_wdata = 16'h0100 + 16'(i);
            cpu_req = (i > 0); cpu_addr = 15'h0005;
            @(negedge clock);
            chk($sformatf("lock.%0d", i), 32'({cpu_gnt, dma_gnt, mem_load}), 32'b011);
            @(posedge clock); #1;
        end
        dma_req = 1'b0; dma_we = 1'b0; dma_lock = 1'b0;
        @(negedge clock);
        chk("lock.release", 32'({cpu_gnt, dma_gnt}), 32'b10);
        @(posedge clock); #1;
        idle_inputs();
        @(posedge clock); #1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("burst_ram.%0d", i), 32'(ram[SCREEN_BASE + 15'(i)]),
                32'(16'h0100 + 16'(i)));
        end

        // Reset asserted while a read is being granted.
        cpu_req = 1'b1; cpu_addr = 15'h0001;
        dma_req = 1'b1; dma_addr = 15'h4001;
        #2;
        chk("pre_reset.cpu_gnt", 32'(cpu_gnt), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("reset.flags", 32'({cpu_gnt, dma_gnt, mem_load, wr_err, cpu_rvalid, dma_rvalid}),
            32'b0);
        chk("reset.mem_address", 32'(mem_address), 32'h0);
        chk("reset.mem_in", 32'(mem_in), 32'h0);
        chk("reset.rdata", 32'({cpu_rdata, dma_rdata}), 32'h0);
        @(posedge clock); #1;
        idle_inputs();
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(negedge clock);
        chk("post_reset.rvalid", 32'({cpu_rvalid, dma_rvalid}), 32'b0);
        @(posedge clock); #1;
        cpu_req = 1'b1; cpu_addr = 15'h0002;
        dma_req = 1'b1; dma_addr = 15'h0003;
        @(negedge clock);
        chk("post_reset.tie", 32'({cpu_gnt, dma_gnt}), 32'b10);
        @(posedge clock); #1;
        idle_inputs();
        @(negedge clock);
        chk("post_reset.cpu_rvalid", 32'({cpu_rvalid, dma_rvalid}), 32'b10);
        chk("post_reset.cpu_rdata", 32'(cpu_rdata), 32'hBBBB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port Hack memory map (16K RAM, 8K screen, keyboard word) between two requesters: the CPU and a DMA/loader port (screen fill, program load).
- Sits between both requesters and the memory block.
- Drives the memory block's `in`, `load` and `address` inputs and returns read data with a one-cycle registered latency.
- Enforces a starvation bound, supports DMA burst lock, and rejects writes outside the writable map.

Parameters:
- STARVE_MAX, 4: maximum consecutive CPU grants while DMA is requesting; the next grant then goes to DMA.
- CPU_PRIORITY, 1: 1 = CPU wins ties; 0 = strict round-robin on ties.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU access request, held until granted
- cpu_we  in  1  CPU write enable (1 = write)
- cpu_addr  in  15  CPU word address
- cpu_wdata  in  16  CPU write data
- cpu_gnt  out  1  CPU request accepted this cycle
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  16  CPU read data
- dma_req  in  1  DMA request, held until granted
- dma_we  in  1  DMA write enable
- dma_lock  in  1  DMA requests an uninterrupted burst
- dma_addr  in  15  DMA word address
- dma_wdata  in  16  DMA write data
- dma_gnt  out  1  DMA request accepted this cycle
- dma_rvalid  out  1  DMA read data valid
- dma_rdata  out  16  DMA read data
- mem_in  out  16  to memory `in`
- mem_load  out  1  to memory `load`
- mem_address  out  15  to memory `address`
- mem_out  in  16  from memory `out`
- wr_err  out  1  one-cycle pulse: a granted write was dropped

Behaviour:
- Reset (async, reset_n = 0): state = ARB; every gnt, rvalid and wr_err = 0; mem_load = 0; rdata registers = 0; starve counter = 0; last_winner = DMA.
- Arbitration is combinational from the current requests plus registered state.
  - Exactly one grant per cycle at most.
  - The grant drives mem_address, mem_in and mem_load in the same cycle.
  - With no grant: mem_load = 0 and mem_address holds its last value.
- States:
  - ARB: normal arbitration.
    - Only one requester active: it is granted.
    - Both active: DMA wins if starve_cnt == STARVE_MAX. Otherwise CPU wins if CPU_PRIORITY = 1; otherwise the requester that is not last_winner wins.
    - A DMA grant with dma_lock = 1 moves to LOCK.
  - LOCK: only DMA can be granted; CPU is held off.
    - Leave to ARB in the cycle dma_lock = 0 or dma_req = 0; that cycle is arbitrated as ARB.
- Starve counter:
  - Increments on each CPU grant while dma_req = 1; saturates at STARVE_MAX.
  - Clears on any DMA grant, and in any cycle where dma_req = 0.
- Write decode:
  - Writable when address < 0x6000: RAM is 0x0000–0x3FFF, screen is 0x4000–0x5FFF.
  - A granted write to an address ≥ 0x6000 is still granted (gnt = 1), but mem_load = 0 and wr_err pulses in the next cycle.
- Reads:
  - Granted read at cycle T: mem_out is captured at the T+1 rising edge into the requester's rdata; that requester's rvalid = 1 for exactly one cycle.
  - A 1-bit registered owner tag routes the data.
  - Back-to-back reads from alternating requesters are allowed; each rvalid pairs with its own grant.
  - rdata holds its value until the next read return to that requester.
- Writes produce no rvalid.
- A requester must keep req/addr/data stable until gnt. Dropping req before gnt is legal; no access occurs.
- Reset asserted mid-access: the in-flight read return is discarded and no rvalid is issued.
- Address wrap: none. 15-bit addresses pass unmodified; out-of-range reads return whatever the memory block drives.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum (ARB, LOCK);
  - the owner enum (OWN_CPU, OWN_DMA);
  - the constants SCREEN_BASE = 15'h4000, KBD_ADDR = 15'h6000, WRITE_LIMIT = 15'h6000.
- One sub-module, arb_pick: combinational winner selection.
  - Inputs: reqs, last_winner, starve_full, state.
  - Outputs: one-hot grant.
- The top level owns all registers.

Test Plan:
- CPU only, write 0x1234 to 0x0010, then read 0x0010 → cpu_gnt high in both request cycles; mem_load = 1 only on the write; cpu_rvalid one cycle after the read grant; cpu_rdata = 0x1234.
- Both requesting continuously, STARVE_MAX = 4, CPU_PRIORITY = 1 → grant pattern CPU,CPU,CPU,CPU,DMA repeating; starve counter never exceeds 4.
- DMA locked burst of 8 writes to 0x4000–0x4007 while cpu_req is held → 8 consecutive dma_gnt, zero cpu_gnt; CPU granted the cycle after dma_lock drops.
- CPU write to 0x6000 with data 0xFFFF → cpu_gnt = 1, mem_load = 0, wr_err pulses one cycle later; a following read of 0x6000 returns the scancode, not 0xFFFF.
- Interleaved reads (CPU 0x0001, DMA 0x4001, CPU 0x0002) on consecutive cycles → rvalids return in order on the correct ports with the correct data; no cross-delivery.
- reset_n pulsed low during a read grant → all outputs 0 immediately; no rvalid after release; first post-reset tie is granted per CPU_PRIORITY.
